// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_pkg.sv
// Shared types and helpers for the aoi222 round-robin grant controller.
// State encoding, requester indices and index arithmetic.
package gf180mcu_fd_sc_mcu9t5v0__arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_st_t;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;

  // Cyclic successor A->B->C->A
  function automatic logic [1:0] nxt_idx(input logic [1:0] i);
    return (i == IDX_C) ? IDX_A : i + 2'd1;
  endfunction

  // One-hot winner to requester index
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    if (oh[1]) return IDX_B;
    if (oh[2]) return IDX_C;
    return IDX_A;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_if.sv
// Request/grant bundle between the requesters and the arbiter.
// master = requesting logic, slave = arbiter.
interface gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_if;
  logic [2:0] REQ;
  logic [2:0] REL;
  logic [2:0] GNT;
  logic       BUSY;
  logic       TOUT;

  modport master (
    output REQ, REL,
    input  GNT, BUSY, TOUT
  );

  modport slave (
    input  REQ, REL,
    output GNT, BUSY, TOUT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_pick3.sv
// Three-way round-robin picker: first requester after last_i wins.
// Purely combinational; vld_o flags that a winner exists.
module gf180mcu_fd_sc_mcu9t5v0__rr_pick3
  import gf180mcu_fd_sc_mcu9t5v0__arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] win_o,
  output logic       vld_o
);

  logic [1:0] p0;
  logic [1:0] p1;
  logic [1:0] p2;

  assign p0 = nxt_idx(last_i);
  assign p1 = nxt_idx(p0);
  assign p2 = nxt_idx(p1);

  // Scan candidates in rotated priority order
  always_comb begin
    win_o = '0;
    if (req_i[p0])      win_o[p0] = 1'b1;
    else if (req_i[p1]) win_o[p1] = 1'b1;
    else if (req_i[p2]) win_o[p2] = 1'b1;
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb.sv
// Round-robin select controller for a shared aoi222 mux.
// One-hot registered grant, one-cycle gap, optional max grant length.
module gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb
  import gf180mcu_fd_sc_mcu9t5v0__arb_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CW      = 4
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_if.slave arb
);

  if (TIMEOUT < 0 || TIMEOUT >= (1 << CW)) begin : g_bad_timeout
    $error("TIMEOUT must lie in 0 .. 2**CW-1");
  end

  localparam logic [CW-1:0] TO   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CMAX = '1;

  arb_st_t       st_q;
  logic [2:0]    gnt_q;
  logic [1:0]    last_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tout_q;

  logic [2:0]    win;
  logic          vld;
  logic [1:0]    last_d;
  logic          rel_hit;
  logic          req_drop;
  logic          to_hit;

  gf180mcu_fd_sc_mcu9t5v0__rr_pick3 u_pick (
    .req_i  (arb.REQ),
    .last_i (last_q),
    .win_o  (win),
    .vld_o  (vld)
  );

  assign last_d   = oh2idx(win);
  assign cnt_d    = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
  assign rel_hit  = |(arb.REL & gnt_q);
  assign req_drop = |(~arb.REQ & gnt_q);
  assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO);

  // Grant FSM with registered grant, length counter and timeout flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= IDLE;
      gnt_q  <= '0;
      last_q <= IDX_C;
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      unique case (st_q)
        IDLE, GAP: begin
          if (vld) begin
            gnt_q  <= win;
            last_q <= last_d;
            cnt_q  <= CW'(1);
            st_q   <= GRANT;
          end else begin
            st_q   <= IDLE;
          end
        end
        GRANT: begin
          if (rel_hit || req_drop || to_hit) begin
            gnt_q  <= '0;
            st_q   <= GAP;
            tout_q <= to_hit && !rel_hit && !req_drop;
          end else begin
            cnt_q  <= cnt_d;
          end
        end
        default: begin
          gnt_q <= '0;
          st_q  <= IDLE;
        end
      endcase
    end
  end

  assign arb.GNT  = gnt_q;
  assign arb.BUSY = |gnt_q;
  assign arb.TOUT = tout_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb.sv
// Bench for the aoi222 round-robin grant controller.
// Directed scenarios plus random traffic against a behavioural model.
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb;

  localparam int TO = 3;
  localparam int CW = 4;

  logic CLK;
  logic RST;
  int   errs;
  int   checks;
  logic [2:0] prev_gnt;

  gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb_if bus ();

  gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb #(
    .TIMEOUT (TO),
    .CW      (CW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .arb (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: who owns the mux, for how long, who went last
  typedef struct {
    int own;
    int len;
    int last;
    bit tout;
  } ms_t;

  ms_t ms;

  function automatic ms_t mstep(input ms_t s,
                                input logic [2:0] req,
                                input logic [2:0] rel);
    ms_t n;
    bit  rh;
    bit  rd;
    bit  th;
    int  c;
    n = s;
    n.tout = 1'b0;
    if (s.own >= 0) begin
      rh = rel[s.own];
      rd = !req[s.own];
      th = (TO != 0) && (s.len == TO);
      if (rh || rd || th) begin
        n.own  = -1;
        n.tout = th && !rh && !rd;
      end else if (s.len < (1 << CW) - 1) begin
        n.len = s.len + 1;
      end
    end else if (req != 3'b000) begin
      for (int k = 1; k <= 3; k++) begin
        c = (s.last + k) % 3;
        if (n.own < 0 && req[c]) begin
          n.own  = c;
          n.last = c;
          n.len  = 1;
        end
      end
    end
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) ms <= '{own: -1, len: 0, last: 2, tout: 1'b0};
    else     ms <= mstep(ms, bus.REQ, bus.REL);
  end

  function automatic logic [2:0] exp_gnt(input ms_t s);
    return (s.own >= 0) ? 3'(1 << s.own) : 3'b000;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance one clock and compare DUT against model
  task automatic tick();
    @(posedge CLK);
    #1;
    if (!RST) begin
      chk("cyc_gnt", 8'(bus.GNT), 8'(exp_gnt(ms)));
      chk("cyc_busy", 8'(bus.BUSY), 8'(ms.own >= 0));
      chk("cyc_tout", 8'(bus.TOUT), 8'(ms.tout));
      chk("onehot", 8'($onehot0(bus.GNT)), 8'd1);
      chk("gap", 8'(prev_gnt != 3'b000 && bus.GNT != 3'b000 &&
                    prev_gnt != bus.GNT), 8'd0);
    end
    prev_gnt = bus.GNT;
  endtask

  // Hand-computed expectation, also pinning the model
  task automatic lit(input string nm,
                     input logic [2:0] g,
                     input logic t);
    chk({nm, "_gnt"}, 8'(bus.GNT), 8'(g));
    chk({nm, "_busy"}, 8'(bus.BUSY), 8'(|g));
    chk({nm, "_tout"}, 8'(bus.TOUT), 8'(t));
    chk({nm, "_model"}, 8'(exp_gnt(ms)), 8'(g));
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    prev_gnt = 3'b000;
    RST      = 1'b1;
    bus.REQ  = 3'b000;
    bus.REL  = 3'b000;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    lit("reset", 3'b000, 1'b0);

    // Full rotation with one-cycle grants
    bus.REQ = 3'b111;
    tick(); lit("rr_a", 3'b001, 1'b0);
    bus.REL = 3'b001;
    tick(); lit("rr_gap1", 3'b000, 1'b0);
    bus.REL = 3'b000;
    tick(); lit("rr_b", 3'b010, 1'b0);
    bus.REL = 3'b010;
    tick(); lit("rr_gap2", 3'b000, 1'b0);
    bus.REL = 3'b000;
    tick(); lit("rr_c", 3'b100, 1'b0);
    bus.REL = 3'b100;
    tick(); lit("rr_gap3", 3'b000, 1'b0);
    bus.REL = 3'b000;
    tick(); lit("rr_a2", 3'b001, 1'b0);
    bus.REL = 3'b001;
    tick();
    bus.REL = 3'b000;
    bus.REQ = 3'b000;
    tick(); lit("rr_idle", 3'b000, 1'b0);

    // Timeout with A alone
    bus.REQ = 3'b001;
    tick(); lit("to_c1", 3'b001, 1'b0);
    tick(); lit("to_c2", 3'b001, 1'b0);
    tick(); lit("to_c3", 3'b001, 1'b0);
    tick(); lit("to_end", 3'b000, 1'b1);
    tick(); lit("to_regrant", 3'b001, 1'b0);
    bus.REQ = 3'b000;
    tick(); lit("to_drop", 3'b000, 1'b0);
    tick();

    // Release from a non-grantee is ignored
    bus.REQ = 3'b011;
    tick(); lit("ign_b", 3'b010, 1'b0);
    bus.REL = 3'b001;
    tick(); lit("ign_hold", 3'b010, 1'b0);
    bus.REL = 3'b010;
    tick(); lit("ign_rel", 3'b000, 1'b0);
    bus.REL = 3'b000;
    bus.REQ = 3'b000;
    tick();

    // Release coincides with timeout
    bus.REQ = 3'b100;
    tick(); lit("rt_c1", 3'b100, 1'b0);
    tick();
    tick(); lit("rt_c3", 3'b100, 1'b0);
    bus.REL = 3'b100;
    tick(); lit("rt_end", 3'b000, 1'b0);
    bus.REL = 3'b000;
    bus.REQ = 3'b000;
    tick();

    // Asynchronous reset mid-grant
    bus.REQ = 3'b100;
    tick(); lit("ar_c", 3'b100, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    lit("ar_clear", 3'b000, 1'b0);
    bus.REQ  = 3'b111;
    prev_gnt = 3'b000;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick(); lit("ar_first", 3'b001, 1'b0);
    bus.REQ = 3'b000;
    tick();
    tick();

    // Random traffic checked every cycle against the model
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.REQ = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) bus.REL = 3'($urandom_range(1, 7));
      else                           bus.REL = 3'b000;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb.md
# gf180mcu_fd_sc_mcu9t5v0__aoi222_rrarb

Round-robin grant controller that shares one aoi222 AND-OR-invert mux between three requesters A, B and C. Its one-hot grant vector drives the mux select pins A2/B2/C2; each requester's data drives A1/B1/C1. The block guarantees that no two selects are ever active together. It inserts a one-cycle all-zero break-before-make gap between grants and enforces a programmable maximum grant length. It sits between the requesting logic and the mux instance in the characterisation/test harness.

## Interface
Parameters:
- TIMEOUT, default 15: maximum consecutive grant cycles before a forced release; 0 disables the timeout.
- CW, default 4: grant-length counter width; TIMEOUT < 2**CW is required (elaboration error otherwise).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; asynchronous, active-high.
- REQ  in  3  request; bit0=A, bit1=B, bit2=C; level, held until served.
- REL  in  3  release strobe per requester; only the bit of the current grantee is honoured.
- GNT  out 3  registered one-hot grant; connects to the mux select pins A2/B2/C2.
- BUSY out 1  high while any GNT bit is high.
- TOUT out 1  one-cycle pulse when a grant is forcibly ended by timeout.

## Operation
- States: IDLE, GRANT, GAP. A 2-bit LAST register holds the index of the most recent grantee.
- IDLE: if REQ is nonzero, pick the first requesting index after LAST in the cyclic order A→B→C→A. Register the winner into GNT, set LAST to it, clear the counter to 1, and go to GRANT. If REQ is zero, stay in IDLE.
- GRANT: the counter increments each cycle and saturates at 2**CW-1. The grant ends at the edge where any of these holds:
  - REL[g]=1;
  - REQ[g]=0;
  - TIMEOUT≠0 and counter==TIMEOUT.
  On that edge GNT←0 and the state goes to GAP. TOUT←1 only if the timeout was the sole cause.
- GAP: GNT stays 0 for exactly one cycle. At the end of that cycle, arbitrate exactly as in IDLE (to GRANT if REQ≠0, else to IDLE).
- A timed-out requester keeps LAST pointing at itself, so it gets lowest priority next round.
- REL bits for non-granted requesters are ignored. REQ changes of non-grantees during GRANT have no effect until the next arbitration.
- REL and timeout in the same cycle: this is a normal release, TOUT=0.
- BUSY = |GNT, taken combinationally from registers only. TOUT is registered.

## Timing
- Reset values: GNT=000, BUSY=0, TOUT=0, state IDLE, LAST=C (so A wins first after reset), counter=0.
- Reset asserted mid-grant clears GNT asynchronously, without waiting for a clock edge. The first grant after deassertion comes at the first edge with RST low and REQ≠0.
- Request latency: REQ sampled at edge k in IDLE → GNT high after edge k.
- Release latency: REL sampled at edge m → GNT low after edge m. The next grant, if any, is high after edge m+1. Back-to-back grants are therefore separated by exactly one all-zero cycle.
- Maximum grant length is TIMEOUT cycles (GNT high for TIMEOUT clock periods).
- GNT never has more than one bit set, including across reset release.

## Structure
- Shared package gf180mcu_fd_sc_mcu9t5v0__arb_pkg contains:
  - the state enum (IDLE, GRANT, GAP);
  - requester index constants (IDX_A=0, IDX_B=1, IDX_C=2);
  - a next-index wrap function.
- One sub-module, gf180mcu_fd_sc_mcu9t5v0__rr_pick3: combinational. Takes REQ[2:0] and LAST[1:0] and returns a one-hot winner plus a valid flag. The FSM, counter and output registers stay in the top level.

## Test plan
- Reset, then REQ=111 held with REL pulsed one cycle after each grant → GNT sequence 001,000,010,000,100,000,001 and BUSY follows.
- TIMEOUT=3, REQ=001 held, no REL → GNT high for 3 cycles, TOUT pulse on the falling edge of GNT, GNT regranted to A after one gap cycle.
- Grant B with REQ=011, then pulse REL[0] (A, not the grantee) → ignored, GNT stays 010 until REL[1] or REQ[1] drops.
- REL[g] and the timeout occur in the same cycle → GNT falls, TOUT stays 0.
- Assert RST asynchronously mid-grant (GNT=100) → GNT=000 before the next edge; after deassertion with REQ=111, the first grant is 001.
- Random REQ/REL for 10k cycles, checked by assertion → GNT is always one-hot or zero, and there is at least one zero cycle between different grantees.
